// File: rtl/vcm_i2c_responder.sv
// vcm_i2c_responder: I2C slave standing in for the VCM driver IC; 2-byte writes load VCM_DATA, reads return it
module vcm_i2c_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h0C,
  parameter int         FILTER_CYC = 3
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        I2C_SCL,
  inout  wire         I2C_SDA,
  output logic [15:0] VCM_DATA,
  output logic        DATA_VALID,
  output logic        BUSY,
  output logic        ADDR_HIT
);
  localparam logic [3:0] FILT = 4'(FILTER_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_IGNORE
  } state_t;

  // index 0 carries SCL, index 1 carries SDA through the input path
  logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic            fscl, fsda, pscl, psda;
  logic            scl_rise, scl_fall, start_c, stop_c;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] vcm_q, vcm_d;
  logic        dv_q, dv_d;
  logic        busy_q, busy_d;
  logic        hit_q, hit_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rd_byte;

  assign fscl     = filt_q[0];
  assign fsda     = filt_q[1];
  assign pscl     = prev_q[0];
  assign psda     = prev_q[1];
  assign scl_rise = fscl & ~pscl;
  assign scl_fall = ~fscl & pscl;
  assign start_c  = fscl & pscl & psda & ~fsda;
  assign stop_c   = fscl & pscl & ~psda & fsda;
  assign rd_byte  = idx_q[0] ? vcm_q[7:0] : vcm_q[15:8];

  assign I2C_SDA    = sda_oe_q ? 1'b0 : 1'bz;
  assign VCM_DATA   = vcm_q;
  assign DATA_VALID = dv_q;
  assign BUSY       = busy_q;
  assign ADDR_HIT   = hit_q;

  // A synchronized level replaces the filtered one only after FILTER_CYC unchanged cycles
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = 4'd0;
      end else if (cnt_q[i] + 4'd1 >= FILT) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = 4'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // Two-flop synchronizer, glitch filter and previous filtered levels for edge detection
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {I2C_SDA, I2C_SCL};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      cnt_q   <= cnt_d;
    end
  end

  // Protocol decode: START/STOP override everything, otherwise act on filtered SCL edges
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rw_d      = rw_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    vcm_d     = vcm_q;
    dv_d      = 1'b0;
    busy_d    = busy_q;
    hit_d     = 1'b0;
    sda_oe_d  = sda_oe_q;
    if (start_c) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], fsda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (shift_q[7:1] == DEV_ADDR) begin
              sda_oe_d = 1'b1;
              hit_d    = 1'b1;
              busy_d   = 1'b1;
              idx_d    = 2'd0;
              rw_d     = shift_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              sda_oe_d = ~rd_byte[7];
              shift_d  = {rd_byte[6:0], 1'b0};
              state_d  = S_RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_WR_BYTE;
            end
          end
        end
        S_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], fsda};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            if (idx_q == 2'd0) begin
              hi_d     = shift_q;
              idx_d    = 2'd1;
              sda_oe_d = 1'b1;
              state_d  = S_WR_ACK;
            end else if (idx_q == 2'd1) begin
              vcm_d    = {hi_q, shift_q};
              dv_d     = 1'b1;
              idx_d    = 2'd2;
              sda_oe_d = 1'b1;
              state_d  = S_WR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else if (bit_cnt_q == 4'd0) begin
              sda_oe_d = ~rd_byte[7];
              shift_d  = {rd_byte[6:0], 1'b0};
            end else begin
              sda_oe_d = ~shift_q[7];
              shift_d  = {shift_q[6:0], 1'b0};
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (fsda) begin
              state_d = S_IGNORE;
            end else begin
              idx_d     = idx_q + 2'd1;
              bit_cnt_d = 4'd0;
              state_d   = S_RD_BYTE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state and registered outputs
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      rw_q      <= 1'b0;
      idx_q     <= 2'd0;
      hi_q      <= 8'd0;
      vcm_q     <= 16'd0;
      dv_q      <= 1'b0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rw_q      <= rw_d;
      idx_q     <= idx_d;
      hi_q      <= hi_d;
      vcm_q     <= vcm_d;
      dv_q      <= dv_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      sda_oe_q  <= sda_oe_d;
    end
  end
endmodule

// File: tb/tb_vcm_i2c_responder.sv
// tb_vcm_i2c_responder: bit-banged I2C master, transaction-level model and per-cycle output checks
module tb_vcm_i2c_responder;
  localparam logic [6:0] DEV = 7'h0C;
  localparam int Q = 31;

  logic clk = 1'b0, rst_n = 1'b1, scl = 1'b1, m_low = 1'b0;
  wire sda;
  logic [15:0] vcm;
  logic dv, busy, hit;

  int checks = 0, errors = 0;
  logic [15:0] wq[$];
  int pend_hits = 0, dv_cnt = 0, hit_cnt = 0;
  logic [15:0] shown_vcm = 16'h0, m_vcm = 16'h0;
  logic [7:0] m_hi = 8'h0;
  logic watch_nd = 1'b0, exp_busy = 1'b0;
  logic t_addr = 1'b0, t_ign = 1'b1, t_rw = 1'b0;
  int t_idx = 0;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #10 clk = ~clk;

  vcm_i2c_responder #(.DEV_ADDR(DEV), .FILTER_CYC(3)) dut (
    .CLK_50(clk), .RESET_N(rst_n), .I2C_SCL(scl), .I2C_SDA(sda),
    .VCM_DATA(vcm), .DATA_VALID(dv), .BUSY(busy), .ADDR_HIT(hit)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // one SCL period; g injects a 1-cycle SCL low and a 2-cycle SDA low while SCL is high
  task automatic bit_io(input logic b, input logic g, output logic r);
    cyc(Q); m_low = ~b;
    cyc(Q); scl = 1'b1;
    cyc(Q); r = sda;
    if (g) begin
      cyc(5); scl = 1'b0;
      cyc(1); scl = 1'b1;
      cyc(8); m_low = 1'b1;
      cyc(2); m_low = ~b;
      cyc(Q - 16);
    end else cyc(Q);
    scl = 1'b0;
  endtask

  task automatic do_start();
    cyc(Q); m_low = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(Q); m_low = 1'b1;
    cyc(Q); scl = 1'b0;
    t_addr = 1'b1; t_ign = 1'b0;
  endtask

  task automatic do_stop();
    cyc(Q); m_low = 1'b1;
    cyc(Q); scl = 1'b1;
    cyc(Q); m_low = 1'b0;
    cyc(Q);
    exp_busy = 1'b0; t_ign = 1'b1; t_addr = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, input logic hold);
    logic exp_ack, r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], i == gbit, r);
    if (t_addr) begin
      t_addr = 1'b0; t_rw = b[0]; t_idx = 0;
      exp_ack = (b[7:1] == DEV);
      if (exp_ack) begin pend_hits++; exp_busy = 1'b1; end
      else t_ign = 1'b1;
    end else if (t_ign || t_rw) exp_ack = 1'b0;
    else if (t_idx == 0) begin m_hi = b; t_idx = 1; exp_ack = 1'b1; end
    else if (t_idx == 1) begin m_vcm = {m_hi, b}; wq.push_back(m_vcm); t_idx = 2; exp_ack = 1'b1; end
    else begin exp_ack = 1'b0; t_ign = 1'b1; end
    if (!hold) begin
      bit_io(1'b1, 1'b0, r);
      chk($sformatf("ack_%02h", b), !r, exp_ack);
    end
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] got);
    logic r;
    logic [7:0] exp;
    exp = (t_idx % 2 == 1) ? m_vcm[7:0] : m_vcm[15:8];
    for (int i = 7; i >= 0; i--) begin bit_io(1'b1, 1'b0, r); got[i] = r; end
    chk("rd_model", got, exp);
    bit_io(nack, 1'b0, r);
    t_idx++;
    if (nack) t_ign = 1'b1;
  endtask

  task automatic settle(input string nm, input logic [15:0] lit);
    cyc(10);
    chk({nm, "_vcm_model"}, vcm, m_vcm);
    chk({nm, "_vcm"}, vcm, lit);
    chk({nm, "_pending_wr"}, wq.size(), 0);
    chk({nm, "_pending_hit"}, pend_hits, 0);
    chk({nm, "_busy"}, busy, exp_busy);
  endtask

  // per-cycle comparison of outputs against the model's expected events
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {vcm, dv, busy, hit}, 0);
      shown_vcm = 16'h0;
      wq.delete();
      pend_hits = 0;
    end else begin
      if (dv) begin
        dv_cnt++;
        chk("dv_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          chk("dv_data", vcm, wq[0]);
          shown_vcm = wq.pop_front();
        end
      end else chk("vcm_stable", vcm, shown_vcm);
      if (hit) begin
        hit_cnt++;
        chk("hit_expected", pend_hits != 0, 1);
        if (pend_hits != 0) pend_hits--;
      end
      if (watch_nd && !m_low) chk("sda_not_driven", sda, 1);
    end
  end

  initial begin
    #(90000 * 20);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, h0;
    logic [7:0] g;
    logic r;
    logic [7:0] b22;
    b22 = 8'h22;
    #5 rst_n = 1'b0;
    cyc(5); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_vcm", vcm, 16'h0);
    chk("rst_dv", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit", hit, 0);
    chk("rst_sda", sda, 1);

    d0 = dv_cnt; h0 = hit_cnt;
    do_start;
    write_byte(8'h18, -1, 1'b0);
    chk("t1_busy_mid", busy, exp_busy);
    write_byte(8'h3F, -1, 1'b0);
    write_byte(8'hA5, -1, 1'b0);
    do_stop;
    settle("t1", 16'h3FA5);
    chk("t1_dv_pulses", dv_cnt - d0, 1);
    chk("t1_hits", hit_cnt - h0, 1);

    d0 = dv_cnt; h0 = hit_cnt;
    watch_nd = 1'b1;
    do_start;
    write_byte(8'h1A, -1, 1'b0);
    write_byte(8'h12, -1, 1'b0);
    write_byte(8'h34, -1, 1'b0);
    do_stop;
    watch_nd = 1'b0;
    settle("t2", 16'h3FA5);
    chk("t2_hits", hit_cnt - h0, 0);
    chk("t2_dv", dv_cnt - d0, 0);

    d0 = dv_cnt;
    do_start;
    write_byte(8'h18, -1, 1'b0);
    write_byte(8'h55, -1, 1'b0);
    do_stop;
    settle("t3a", 16'h3FA5);
    chk("t3a_dv", dv_cnt - d0, 0);
    do_start;
    write_byte(8'h18, -1, 1'b0);
    write_byte(8'h01, -1, 1'b0);
    write_byte(8'h02, -1, 1'b0);
    write_byte(8'h03, -1, 1'b0);
    settle("t3b", 16'h0102);

    do_start;
    write_byte(8'h19, -1, 1'b0);
    read_byte(1'b0, g); chk("t4_byte0", g, 8'h01);
    read_byte(1'b0, g); chk("t4_byte1", g, 8'h02);
    read_byte(1'b1, g); chk("t4_byte2", g, 8'h01);
    cyc(Q);
    chk("t4_release", sda, 1);
    do_stop;
    settle("t4", 16'h0102);

    d0 = dv_cnt;
    do_start;
    write_byte(8'h18, 4, 1'b0);
    write_byte(8'hBE, -1, 1'b0);
    write_byte(8'hEF, -1, 1'b0);
    do_stop;
    settle("t5", 16'hBEEF);
    chk("t5_dv", dv_cnt - d0, 1);

    do_start;
    write_byte(8'h18, -1, 1'b0);
    write_byte(8'h11, -1, 1'b0);
    write_byte(b22, -1, 1'b1);
    cyc(Q); m_low = 1'b0;
    cyc(Q); scl = 1'b1;
    cyc(Q);
    chk("t6_ack_drive", sda, 0);
    chk("t6_vcm_pre", vcm, 16'h1122);
    rst_n = 1'b0;
    m_vcm = 16'h0; exp_busy = 1'b0; t_ign = 1'b1; t_addr = 1'b0;
    @(negedge clk);
    chk("t6_sda_release", sda, 1);
    chk("t6_outs", {vcm, dv, busy, hit}, 0);
    cyc(3); rst_n = 1'b1;
    cyc(Q); scl = 1'b0;
    do_stop;
    do_start;
    write_byte(8'h18, -1, 1'b0);
    write_byte(8'h00, -1, 1'b0);
    write_byte(8'hFF, -1, 1'b0);
    do_stop;
    settle("t6", 16'h00FF);

    cyc(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vcm_i2c_responder.md
Name: vcm_i2c_responder

Overview:
I2C slave that emulates the voice-coil-motor driver IC on the CLK_50 domain. It is the far end of the focus-stepping I2C write path, used as a loopback/bench target and as a stand-in when no lens module is fitted. It decodes 2-byte write transactions into a 16-bit VCM_DATA word and answers reads with the currently held word.

Parameters:
DEV_ADDR, 7'h0C, 7-bit slave address; write byte 0x18, read byte 0x19.
FILTER_CYC, 3, consecutive CLK_50 cycles a synchronized SCL/SDA level must be stable before it is accepted (1..15).

Ports:
CLK_50  input  1  system clock, 50 MHz.
RESET_N  input  1  asynchronous active-low reset.
I2C_SCL  input  1  bus clock from the master.
I2C_SDA  inout  1  bus data; driven only as 0 or Z (open drain).
VCM_DATA  output  16  last complete written word, {byte1, byte2}.
DATA_VALID  output  1  one-cycle pulse when VCM_DATA updates.
BUSY  output  1  high from an address-matched START until STOP.
ADDR_HIT  output  1  one-cycle pulse on each address match (read or write).

Behaviour:
- Reset (async assert, sync release): VCM_DATA=0, DATA_VALID=0, BUSY=0, ADDR_HIT=0, SDA released (Z), FSM=IDLE. Filtered SCL and SDA reset to 1.
- Input path: 2-FF synchronizer, then FILTER_CYC stability filter. All edge detection uses the filtered signals (fSCL, fSDA). Pin-to-decision latency is 2+FILTER_CYC cycles.
- START: fSDA 1->0 while fSCL=1. Taken from any state, including a repeated START, and goes to ADDR with bit counter = 0.
- STOP: fSDA 0->1 while fSCL=1. Taken from any state; goes to IDLE, releases SDA, clears BUSY.
- Bits are sampled on the fSCL rising edge, MSB first. SDA drive changes only on the fSCL falling edge.
- FSM states:
  - IDLE: waits for START.
  - ADDR: shifts 8 bits. On the 8th-bit falling edge, if addr[7:1]==DEV_ADDR, drive ACK (SDA=0), pulse ADDR_HIT, set BUSY, byte index = 0, and enter ADDR_ACK. On a mismatch, stay released (NACK) and go to IGNORE.
  - ADDR_ACK: release SDA on the next fSCL falling edge. Then go to WR_BYTE if R/W=0, or RD_BYTE if R/W=1; RD_BYTE drives the first bit on that same falling edge.
  - WR_BYTE: shifts 8 bits.
    - Index 0: store the high byte and ACK.
    - Index 1: ACK; on the cycle ACK drive begins, VCM_DATA <= {hi, lo} and DATA_VALID pulses once.
    - Index >= 2: NACK, then go to IGNORE.
  - WR_ACK: holds the ACK for one SCL period, then returns to WR_BYTE.
  - RD_BYTE: drives VCM_DATA[15:8] for even index and [7:0] for odd index, as 0 or Z per bit. Index wraps, so the 3rd byte is the high byte again.
  - RD_ACK: releases SDA and samples the master's bit on the fSCL rise. 0 (ACK) continues with the next byte; 1 (NACK) goes to IGNORE.
  - IGNORE: SDA released; waits for START or STOP.
- Partial write (STOP/START before the second ACK): VCM_DATA unchanged, no DATA_VALID.
- Write data is held in a staging register. VCM_DATA never shows a half-updated word.
- The slave never stretches SCL.
- Reset mid-transaction: immediate SDA release, all state cleared. The next transfer requires a fresh START.
- SDA and SCL changing in the same filtered cycle: SCL edge processing takes priority; START/STOP are evaluated only while fSCL stays 1 in both the previous and current cycle.

Test Plan:
- Write 0x18,0x3F,0xA5 at 400 kHz then STOP -> ACK on all 3 bytes; VCM_DATA=16'h3FA5; exactly one DATA_VALID pulse; one ADDR_HIT; BUSY falls at STOP.
- Address 0x1A,0x12,0x34 -> NACK on address; SDA never driven low; VCM_DATA unchanged; no ADDR_HIT.
- Write 0x18,0x55 then STOP -> ACK, ACK; VCM_DATA keeps 0x3FA5; no DATA_VALID. Then 0x18,0x01,0x02,0x03 -> ACK, ACK, ACK, NACK; VCM_DATA=16'h0102.
- With VCM_DATA=16'h0102: repeated START, read 0x19, master ACK, ACK, NACK -> slave returns 0x01, 0x02, 0x01; SDA released after NACK.
- 1-cycle SCL low glitch and 2-cycle SDA glitch during an address bit (FILTER_CYC=3) -> ignored; transaction completes with 16'hBEEF.
- Assert RESET_N during the second write byte -> SDA=Z within one cycle; all outputs 0; after release, a full write of 16'h00FF succeeds.
